// File: rtl/goboard_pkg.sv
// Shared constants, FSM state type and helpers for the goboard info-text
// write path. Everything in the sys_clk_in domain imports this package.
package goboard_pkg;

  // Info-text RAM geometry: 512 character cells, one ASCII byte each.
  localparam int INFO_CELLS = 512;
  localparam int INFO_AW    = 9;

  // Value written to every cell by a screen clear.
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  // Burst lengths are carried on 6 bits with 0 standing for 64, so the
  // remaining-count register needs one extra bit.
  localparam int LEN_W = 6;
  localparam int CNT_W = LEN_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    CLEAR
  } state_t;

  // Expand a 6-bit burst length field into a character count (0 -> 64).
  function automatic logic [CNT_W-1:0] burst_count(input logic [LEN_W-1:0] len);
    return (len == '0) ? CNT_W'(64) : {1'b0, len};
  endfunction

endpackage

// File: rtl/goboard_info_arbiter_if.sv
// Bundle of the requester, clear and RAM write-port signals around the
// info-text arbiter. The slave modport is the arbiter's view; the master
// modport is the view of whatever drives the requests and watches the RAM port.
interface goboard_info_arbiter_if;
  import goboard_pkg::*;

  // Screen-clear sequencer
  logic                 clr_req_i;
  logic                 clr_busy_o;

  // Requester 0: game-log writer
  logic                 req0_i;
  logic [INFO_AW-1:0]   req0_addr_i;
  logic [LEN_W-1:0]     req0_len_i;
  logic                 grant0_o;
  logic [7:0]           char0_i;
  logic                 char0_valid_i;
  logic                 char0_ready_o;

  // Requester 1: status-line writer
  logic                 req1_i;
  logic [INFO_AW-1:0]   req1_addr_i;
  logic [LEN_W-1:0]     req1_len_i;
  logic                 grant1_o;
  logic [7:0]           char1_i;
  logic                 char1_valid_i;
  logic                 char1_ready_o;

  // Info-text RAM write port
  logic                 wea_o;
  logic [7:0]           ascii_o;
  logic [INFO_AW-1:0]   write_ram_addr_o;

  modport slave (
    input  clr_req_i,
    output clr_busy_o,
    input  req0_i, req0_addr_i, req0_len_i, char0_i, char0_valid_i,
    output grant0_o, char0_ready_o,
    input  req1_i, req1_addr_i, req1_len_i, char1_i, char1_valid_i,
    output grant1_o, char1_ready_o,
    output wea_o, ascii_o, write_ram_addr_o
  );

  modport master (
    output clr_req_i,
    input  clr_busy_o,
    output req0_i, req0_addr_i, req0_len_i, char0_i, char0_valid_i,
    input  grant0_o, char0_ready_o,
    output req1_i, req1_addr_i, req1_len_i, char1_i, char1_valid_i,
    input  grant1_o, char1_ready_o,
    input  wea_o, ascii_o, write_ram_addr_o
  );

endinterface

// File: rtl/goboard_rr_arb2.sv
// Two-way round-robin picker. The grant is combinational from the request
// lines; the last-grant register only moves when the caller strobes advance,
// so the owner of a tie flips exactly once per granted job.
module goboard_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // 1 means requester 1 was granted last, so requester 0 wins the first tie.
  logic last_grant;

  // Pick the sole requester, or the one not served last when both ask.
  always_comb begin
    // NOTE: assign a default before the case so every path drives grant and
    // no latch is inferred for the unlisted request patterns.
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Remember who was served whenever the caller commits a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values and simulation matches the synthesized netlist.
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/goboard_info_arbiter.sv
// Owns the single write port of the goboard info-text RAM. Two burst
// requesters share it round-robin; a screen-clear sequencer preempts both
// between jobs and fills all 512 cells with spaces, one per cycle.
module goboard_info_arbiter
  import goboard_pkg::*;
(
  input  logic                    sys_clk_in,
  input  logic                    arst_n_i,
  goboard_info_arbiter_if.slave   bus
);

  state_t             state;
  logic               grant0_q;
  logic               grant1_q;
  logic [INFO_AW-1:0] addr_cnt;
  logic [CNT_W-1:0]   rem_cnt;
  logic               pending;

  logic               wea_q;
  logic [7:0]         ascii_q;
  logic [INFO_AW-1:0] addr_q;

  logic [1:0]         arb_grant;
  logic               arb_advance;
  logic               rem_nz;
  logic               ready0;
  logic               ready1;
  logic               hs;
  logic [7:0]         hs_char;

  // A pending clear outranks both requesters, so the picker is only asked
  // to commit when IDLE has no clear waiting.
  assign arb_advance = (state == IDLE) && !pending;

  goboard_rr_arb2 u_rr_arb2 (
    .clk     (sys_clk_in),
    .rst_n   (arst_n_i),
    .req     ({bus.req1_i, bus.req0_i}),
    .advance (arb_advance),
    .grant   (arb_grant)
  );

  // The grant registers double as the one-hot burst owner; ready is offered
  // only to the owner and only while characters remain in its burst.
  assign rem_nz  = (rem_cnt != '0);
  assign ready0  = grant0_q & rem_nz;
  assign ready1  = grant1_q & rem_nz;
  assign hs      = (ready0 & bus.char0_valid_i) | (ready1 & bus.char1_valid_i);
  assign hs_char = grant1_q ? bus.char1_i : bus.char0_i;

  assign bus.grant0_o         = grant0_q;
  assign bus.grant1_o         = grant1_q;
  assign bus.char0_ready_o    = ready0;
  assign bus.char1_ready_o    = ready1;
  assign bus.clr_busy_o       = pending | (state == CLEAR);
  assign bus.wea_o            = wea_q;
  assign bus.ascii_o          = ascii_q;
  assign bus.write_ram_addr_o = addr_q;

  // Job FSM with its counters and the registered RAM write port. Reset
  // abandons any job; wea_q clears with it, so no partial write follows.
  always_ff @(posedge sys_clk_in or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state    <= IDLE;
      grant0_q <= 1'b0;
      grant1_q <= 1'b0;
      addr_cnt <= '0;
      rem_cnt  <= '0;
      pending  <= 1'b0;
      wea_q    <= 1'b0;
      ascii_q  <= '0;
      addr_q   <= '0;
    end else begin
      wea_q   <= 1'b0;
      // A clear request is remembered in every state, including CLEAR itself,
      // where it re-arms one more full pass.
      pending <= pending | bus.clr_req_i;

      case (state)
        IDLE: begin
          if (pending) begin
            // Entering CLEAR consumes the pending flag, but a request arriving
            // in this very cycle must still be kept.
            state    <= CLEAR;
            addr_cnt <= '0;
            pending  <= bus.clr_req_i;
          end else if (arb_grant != 2'b00) begin
            state    <= BURST;
            grant0_q <= arb_grant[0];
            grant1_q <= arb_grant[1];
            addr_cnt <= arb_grant[1] ? bus.req1_addr_i : bus.req0_addr_i;
            rem_cnt  <= burst_count(arb_grant[1] ? bus.req1_len_i : bus.req0_len_i);
          end
        end

        BURST: begin
          if (hs) begin
            wea_q    <= 1'b1;
            ascii_q  <= hs_char;
            addr_q   <= addr_cnt;
            addr_cnt <= addr_cnt + 1'b1;
            rem_cnt  <= rem_cnt - 1'b1;
            if (rem_cnt == CNT_W'(1)) begin
              state    <= IDLE;
              grant0_q <= 1'b0;
              grant1_q <= 1'b0;
            end
          end
        end

        CLEAR: begin
          wea_q    <= 1'b1;
          ascii_q  <= CHAR_SPACE;
          addr_q   <= addr_cnt;
          addr_cnt <= addr_cnt + 1'b1;
          if (addr_cnt == INFO_AW'(INFO_CELLS - 1)) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_goboard_info_arbiter.sv
// Self-checking bench for goboard_info_arbiter. Stimulus tasks push every
// RAM write they expect into a scoreboard queue; a negedge monitor pops and
// compares each write the DUT issues.
module tb_goboard_info_arbiter;
  import goboard_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  goboard_info_arbiter_if bus ();

  goboard_info_arbiter dut (
    .sys_clk_in (clk),
    .arst_n_i   (rst_n),
    .bus        (bus.slave)
  );

  typedef struct packed {
    logic [8:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks  = 0;
  int  n_errors  = 0;
  int  wr_count  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: every write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && bus.wea_o) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("spurious_write", 32'(bus.wea_o), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(bus.write_ram_addr_o), 32'(mon_e.addr));
        check("wr_data", 32'(bus.ascii_o), 32'(mon_e.data));
      end
    end
  end

  function automatic logic [31:0] out_vec();
    return 32'({bus.grant1_o, bus.grant0_o, bus.char1_ready_o, bus.char0_ready_o,
                bus.clr_busy_o, bus.wea_o, bus.ascii_o, bus.write_ram_addr_o});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    exp_q.delete();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic push_clear();
    wr_t e;
    for (int i = 0; i < INFO_CELLS; i++) begin
      e.addr = 9'(i);
      e.data = CHAR_SPACE;
      exp_q.push_back(e);
    end
  endtask

  // One burst from requester n. Characters are base, base+1, ...; with
  // toggle set, valid is only offered on every other cycle. Each cycle the
  // write port must reflect exactly the previous cycle's handshake.
  task automatic run_burst(input bit n, input logic [8:0] a, input logic [5:0] len,
                           input logic [7:0] base, input bit toggle, output int lat);
    int  l;
    int  accepted;
    int  cyc;
    bit  v;
    bit  rdy;
    bit  prev_hs;
    wr_t e;
    l = (len == 6'd0) ? 64 : int'(len);
    for (int i = 0; i < l; i++) begin
      e.addr = a + 9'(i);
      e.data = base + 8'(i);
      exp_q.push_back(e);
    end
    if (n) begin
      bus.req1_i = 1'b1; bus.req1_addr_i = a; bus.req1_len_i = len;
    end else begin
      bus.req0_i = 1'b1; bus.req0_addr_i = a; bus.req0_len_i = len;
    end
    lat = 0;
    while (!(n ? bus.grant1_o : bus.grant0_o) && lat < 50) begin
      step();
      lat++;
    end
    if (n) bus.req1_i = 1'b0; else bus.req0_i = 1'b0;
    if (!(n ? bus.grant1_o : bus.grant0_o)) begin
      check("grant_timeout", 32'(n ? bus.grant1_o : bus.grant0_o), 32'd1);
      return;
    end
    accepted = 0;
    cyc      = 0;
    prev_hs  = 1'b0;
    while (accepted < l && cyc < 400) begin
      check("wea_vs_handshake", 32'(bus.wea_o), 32'(prev_hs));
      check("burst_grant_held", 32'(n ? bus.grant1_o : bus.grant0_o), 32'd1);
      v   = toggle ? (cyc % 2 == 0) : 1'b1;
      rdy = n ? bus.char1_ready_o : bus.char0_ready_o;
      if (n) begin
        bus.char1_valid_i = v; bus.char1_i = base + 8'(accepted);
      end else begin
        bus.char0_valid_i = v; bus.char0_i = base + 8'(accepted);
      end
      @(posedge clk);
      prev_hs = rdy && v;
      if (prev_hs) accepted++;
      #1;
      cyc++;
    end
    bus.char0_valid_i = 1'b0;
    bus.char1_valid_i = 1'b0;
    check("burst_accepted", 32'(accepted), 32'(l));
    check("last_write", 32'(bus.wea_o), 32'(prev_hs));
    check("burst_grant_drop", 32'(n ? bus.grant1_o : bus.grant0_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    int  snap;
    int  k;
    int  ngr;
    int  wc;
    int  busy_cnt;
    int  busy_low;
    int  order[4];
    logic [1:0] g;
    logic [1:0] prev_g;
    wr_t e0;
    wr_t e1;

    bus.clr_req_i     = 1'b0;
    bus.req0_i        = 1'b0; bus.req0_addr_i = '0; bus.req0_len_i = '0;
    bus.char0_i       = '0;   bus.char0_valid_i = 1'b0;
    bus.req1_i        = 1'b0; bus.req1_addr_i = '0; bus.req1_len_i = '0;
    bus.char1_i       = '0;   bus.char1_valid_i = 1'b0;

    // Reset state
    #1;
    check("reset_outputs", out_vec(), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("post_reset_outputs", out_vec(), 32'd0);

    // Short full-rate burst from requester 0
    run_burst(1'b0, 9'h010, 6'd3, 8'h41, 1'b0, lat);
    check("t1_grant_latency", 32'(lat), 32'd1);
    step();
    check("t1_idle_after", out_vec() & 32'h7C0000, 32'd0);

    // Round robin after reset: requester 0 wins the first tie
    do_reset();
    e0.addr = 9'h020; e0.data = 8'h30;
    e1.addr = 9'h040; e1.data = 8'h31;
    exp_q.push_back(e0); exp_q.push_back(e1);
    exp_q.push_back(e0); exp_q.push_back(e1);
    bus.req0_i = 1'b1; bus.req0_addr_i = 9'h020; bus.req0_len_i = 6'd1;
    bus.char0_i = 8'h30; bus.char0_valid_i = 1'b1;
    bus.req1_i = 1'b1; bus.req1_addr_i = 9'h040; bus.req1_len_i = 6'd1;
    bus.char1_i = 8'h31; bus.char1_valid_i = 1'b1;
    prev_g = 2'b00;
    ngr    = 0;
    k      = 0;
    while (ngr < 4 && k < 40) begin
      step();
      g = {bus.grant1_o, bus.grant0_o};
      if (g != 2'b00 && g != prev_g) begin
        check("rr_idle_gap", 32'(prev_g), 32'd0);
        order[ngr] = int'(g[1]);
        ngr++;
        if (ngr == 4) begin
          bus.req0_i = 1'b0;
          bus.req1_i = 1'b0;
        end
      end
      prev_g = g;
      k++;
    end
    check("rr_grant_count", 32'(ngr), 32'd4);
    for (int i = 0; i < ngr; i++) check("rr_order", 32'(order[i]), 32'(i % 2));
    step();
    bus.char0_valid_i = 1'b0;
    bus.char1_valid_i = 1'b0;
    repeat (4) step();
    check("rr_no_extra_grant", 32'({bus.grant1_o, bus.grant0_o}), 32'd0);

    // Address wrap from 0x1FE
    run_burst(1'b1, 9'h1FE, 6'd2, 8'h61, 1'b0, lat);
    step();

    // Length 0 means 64, with valid toggling
    snap = wr_count;
    run_burst(1'b0, 9'h100, 6'd0, 8'h40, 1'b1, lat);
    step();
    check("len0_write_count", 32'(wr_count - snap), 32'd64);

    // Clear requested mid-burst waits, then runs 512 consecutive writes
    fork
      run_burst(1'b0, 9'h080, 6'd5, 8'h61, 1'b0, lat);
      begin
        step();
        step();
        bus.clr_req_i = 1'b1;
        step();
        bus.clr_req_i = 1'b0;
        check("busy_after_pulse", 32'(bus.clr_busy_o), 32'd1);
        push_clear();
      end
    join
    k        = 0;
    busy_low = 0;
    while (!(bus.wea_o && bus.ascii_o == CHAR_SPACE) && k < 20) begin
      if (!bus.clr_busy_o) busy_low++;
      step();
      k++;
    end
    check("busy_before_clear", 32'(busy_low), 32'd0);
    check("clear_started", 32'(bus.wea_o), 32'd1);
    wc       = 0;
    busy_cnt = 0;
    for (int i = 0; i < INFO_CELLS; i++) begin
      wc += int'(bus.wea_o);
      if (i < INFO_CELLS - 1) busy_cnt += int'(bus.clr_busy_o);
      step();
    end
    check("clear_consecutive", 32'(wc), 32'd512);
    check("busy_during_clear", 32'(busy_cnt), 32'd511);
    check("busy_fall", 32'(bus.clr_busy_o), 32'd0);
    check("clear_done_no_write", 32'(bus.wea_o), 32'd0);

    // Reset in the middle of a clear
    step();
    bus.clr_req_i = 1'b1;
    step();
    bus.clr_req_i = 1'b0;
    push_clear();
    k = 0;
    while (!(bus.wea_o && bus.write_ram_addr_o == 9'd100) && k < 600) begin
      step();
      k++;
    end
    check("reached_addr_100", 32'(bus.write_ram_addr_o), 32'd100);
    #1 rst_n = 1'b0;
    #1;
    check("reset_mid_clear", out_vec(), 32'd0);
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    snap  = wr_count;
    repeat (20) step();
    check("no_write_after_reset", 32'(wr_count - snap), 32'd0);
    check("idle_after_reset", out_vec(), 32'd0);
    run_burst(1'b1, 9'h1F0, 6'd1, 8'h5A, 1'b0, lat);
    check("recovery_grant_latency", 32'(lat), 32'd1);
    step();
    step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
